if_id_stage: RTL and testbench
==============================

# if_id_stage

IF/ID pipeline stage of the RV32I core: accepts fetched instruction/PC pairs through a valid/ready handshake, buffers them in a two-entry skid buffer, and presents them to decode. At capture time it classifies each instruction's opcode into the 3-bit immediate-select code consumed by the downstream immediate generator, so decode receives instruction, PC and immediate select aligned in the same cycle. Supports full-throughput streaming, back-pressure and synchronous flush for branch/jump redirect and watchdog recovery.

## Interface
- RESET_INSTR, 32'h0000_0013, instruction value held on `out_instr` after reset and flush (NOP, addi x0,x0,0)
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage can accept; high iff skid entry empty
- in_instr  in  32  fetched instruction word
- in_pc  in  32  PC of `in_instr`
- flush  in  1  discard all buffered and incoming instructions
- out_valid  out  1  head entry valid toward decode
- out_ready  in  1  decode consumes head entry
- out_instr  out  32  head instruction
- out_pc  out  32  head PC
- out_imm_sel  out  3  immediate select for head: 000 S, 001 I, 010 JAL, 011 B, 100 U
- out_illegal  out  1  head opcode not RV32I (see Configuration)

## Operation
- Entries: head (drives outputs) and skid; each holds instr, pc, imm_sel, illegal.
- States: EMPTY (no valid entry), ONE (head valid), FULL (head + skid valid).
- push = in_valid & in_ready; pop = out_valid & out_ready.
- EMPTY: push -> ONE (load head).
- ONE: push & pop -> ONE (head reloaded); push only -> FULL (load skid); pop only -> EMPTY.
- FULL: pop -> ONE (skid moves to head); in_ready=0 so no push.
- flush (highest priority): next state EMPTY, head fields <= RESET_INSTR/0/001/0, incoming word in flush cycle dropped even if in_ready=1.
- imm_sel decoded combinationally from in_instr[6:0] and stored with entry: 0010011, 0000011, 1100111, 1110011 -> 001; 0100011 -> 000; 1101111 -> 010; 1100011 -> 011; 0110111, 0010111 -> 100; all other opcodes (incl. R-type 0110011, 0001111) -> 001.
- Entries are never overwritten while valid and not popped; order strictly FIFO.

## Timing
- Reset (rst_n low at edge): state EMPTY, out_valid=0, in_ready=1 after the edge, out_instr=RESET_INSTR, out_pc=0, out_imm_sel=001, out_illegal=0.
- Latency: word pushed at edge N appears with out_valid=1 after edge N; throughput one per cycle while out_ready=1.
- in_ready is registered (function of state only); no combinational path from out_ready to in_ready.
- Outputs are registered; no combinational path from in_* to out_*.
- Reset asserted mid-stream overrides flush and handshake; all buffered entries lost.

## Configuration
- `IF_ID_ILLEGAL_CHECK_EN` defined: out_illegal=1 when in_instr[1:0]!=2'b11 or opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111, 1110011}; flag stored per entry.
- Not defined: illegal logic and storage removed; out_illegal tied 0.

## Structure
- Shared package `rv32i_pkg`: opcode localparams, `imm_sel_t` enum (IMM_S, IMM_I, IMM_J, IMM_B, IMM_U with the codes above), stage-state enum.
- One sub-module: `imm_sel_decode` (combinational opcode -> imm_sel, illegal), instantiated once on the input side.

## Test plan
- Reset, then push 0x00500093 (addi) pc 0x0, out_ready=1 -> next cycle out_valid=1, out_instr=0x00500093, out_imm_sel=001; following cycle out_valid=0.
- Stream sw 0x00112023, beq 0x00208463, jal 0x008000EF, lui 0x123452B7 back-to-back, out_ready=1 -> imm_sel 000, 011, 010, 100 on consecutive cycles, in_ready stays 1.
- out_ready=0, push two words -> state FULL, in_ready=0 one cycle after second push; out_ready=1 -> both emerge in order, in_ready returns 1.
- FULL with flush=1 and in_valid=1 -> next cycle out_valid=0, out_instr=0x00000013, in_ready=1; dropped word never appears.
- With `IF_ID_ILLEGAL_CHECK_EN`: push 0x0000007F -> out_illegal=1, imm_sel=001; without macro -> out_illegal=0.
- rst_n low while FULL -> after edge out_valid=0, in_ready=1, out_pc=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: opcodes, immediate-select codes, IF/ID entry layout.
// Entry carries the illegal flag only when IF_ID_ILLEGAL_CHECK_EN is defined.
package rv32i_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] RESET_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_S = 3'b000,
    IMM_I = 3'b001,
    IMM_J = 3'b010,
    IMM_B = 3'b011,
    IMM_U = 3'b100
  } imm_sel_t;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} stage_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    imm_sel_t    imm_sel;
`ifdef IF_ID_ILLEGAL_CHECK_EN
    logic        illegal;
`endif
  } entry_t;

  function automatic entry_t reset_entry();
    entry_t e;
    e         = '0;
    e.instr   = RESET_INSTR;
    e.imm_sel = IMM_I;
    return e;
  endfunction

endpackage

// File: rtl/imm_sel_decode.sv
// Combinational opcode classifier: immediate-select code and, with
// IF_ID_ILLEGAL_CHECK_EN defined, an illegal-opcode flag.
module imm_sel_decode
  import rv32i_pkg::*;
(
  input  logic [6:0] opcode,
  output imm_sel_t   imm_sel
`ifdef IF_ID_ILLEGAL_CHECK_EN
  ,
  output logic       illegal
`endif
);

  always_comb begin
    imm_sel = IMM_I;
    case (opcode)
      OP_STORE:        imm_sel = IMM_S;
      OP_JAL:          imm_sel = IMM_J;
      OP_BRANCH:       imm_sel = IMM_B;
      OP_LUI, OP_AUIPC: imm_sel = IMM_U;
      default:         imm_sel = IMM_I;
    endcase
  end

`ifdef IF_ID_ILLEGAL_CHECK_EN
  // Every listed opcode ends in 2'b11, so compressed encodings fall to default.
  always_comb begin
    illegal = 1'b1;
    case (opcode)
      OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
      OP_LUI, OP_AUIPC, OP_FENCE, OP_SYSTEM: illegal = 1'b0;
      default:                               illegal = 1'b1;
    endcase
  end
`endif

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: two-entry skid buffer with capture-time imm_sel decode.
// Optional illegal-opcode flag enabled by defining IF_ID_ILLEGAL_CHECK_EN.
module if_id_stage
  import rv32i_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [2:0]  out_imm_sel,
  output logic        out_illegal
);

  stage_state_t state_q, state_d;
  entry_t       head_q, head_d, skid_q, skid_d, in_entry;
  imm_sel_t     in_imm_sel;
  logic         push, pop;

`ifdef IF_ID_ILLEGAL_CHECK_EN
  logic in_illegal;

  imm_sel_decode u_decode (
    .opcode  (in_instr[6:0]),
    .imm_sel (in_imm_sel),
    .illegal (in_illegal)
  );
`else
  imm_sel_decode u_decode (
    .opcode  (in_instr[6:0]),
    .imm_sel (in_imm_sel)
  );
`endif

  always_comb begin
    in_entry         = reset_entry();
    in_entry.instr   = in_instr;
    in_entry.pc      = in_pc;
    in_entry.imm_sel = in_imm_sel;
`ifdef IF_ID_ILLEGAL_CHECK_EN
    in_entry.illegal = in_illegal;
`endif
  end

  // Handshake flags depend on registered state only.
  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = StEmpty;
      head_d  = reset_entry();
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (push) begin
            head_d  = in_entry;
            state_d = StOne;
          end
        end
        StOne: begin
          if (push && pop) begin
            head_d = in_entry;
          end else if (push) begin
            skid_d  = in_entry;
            state_d = StFull;
          end else if (pop) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (pop) begin
            head_d  = skid_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      head_q  <= reset_entry();
      skid_q  <= reset_entry();
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign out_instr   = head_q.instr;
  assign out_pc      = head_q.pc;
  assign out_imm_sel = head_q.imm_sel;
`ifdef IF_ID_ILLEGAL_CHECK_EN
  assign out_illegal = head_q.illegal;
`else
  assign out_illegal = 1'b0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus a scoreboard
// that checks every word decode consumes, in order.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, out_instr, out_pc;
  logic [2:0]  out_imm_sel;

  int vectors = 0;
  int errors  = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  sel;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  if_id_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .out_imm_sel (out_imm_sel),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] model_sel(input logic [31:0] w);
    case (w[6:0])
      7'h23:        return 3'b000;
      7'h6f:        return 3'b010;
      7'h63:        return 3'b011;
      7'h37, 7'h17: return 3'b100;
      default:      return 3'b001;
    endcase
  endfunction

  function automatic logic model_ill(input logic [31:0] w);
`ifdef IF_ID_ILLEGAL_CHECK_EN
    case (w[6:0])
      7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17, 7'h0f, 7'h73:
        return 1'b0;
      default: return 1'b1;
    endcase
`else
    return w[0] & ~w[0];
`endif
  endfunction

  function automatic exp_t mk(input logic [31:0] w, input logic [31:0] p);
    exp_t e;
    e.instr = w;
    e.pc    = p;
    e.sel   = model_sel(w);
    e.ill   = model_ill(w);
    return e;
  endfunction

  // Scoreboard: pop/compare on consume, push on accept, drop all on flush/reset.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: got instr=%h pc=%h, required none", out_instr, out_pc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({out_instr, out_pc, out_imm_sel, out_illegal} !== e) begin
            errors++;
            $display("FAIL sb_data: got instr=%h pc=%h sel=%b ill=%b, required %h %h %b %b",
                     out_instr, out_pc, out_imm_sel, out_illegal, e.instr, e.pc, e.sel, e.ill);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(mk(in_instr, in_pc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] p);
    in_valid = v;
    in_instr = w;
    in_pc    = p;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step(); step();
    vectors++;
    if ({out_valid, in_ready, out_instr, out_pc, out_imm_sel, out_illegal} !==
        {1'b0, 1'b1, 32'h13, 32'h0, 3'b001, 1'b0}) begin
      errors++;
      $display("FAIL reset: got v=%b r=%b i=%h pc=%h sel=%b ill=%b, required 0 1 13 0 001 0",
               out_valid, in_ready, out_instr, out_pc, out_imm_sel, out_illegal);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    drive(1'b1, 32'h0050_0093, 32'h0);
    step();
    drive(1'b0, 32'h0, 32'h0);
    vectors++;
    if ({out_valid, out_instr, out_imm_sel} !== {1'b1, 32'h0050_0093, 3'b001}) begin
      errors++;
      $display("FAIL single_out: got v=%b i=%h sel=%b, required 1 00500093 001",
               out_valid, out_instr, out_imm_sel);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_stream();
    logic [31:0] words [4];
    logic [2:0]  sels  [4];
    words = '{32'h0011_2023, 32'h0020_8463, 32'h0080_00EF, 32'h1234_52B7};
    sels  = '{3'b000, 3'b011, 3'b010, 3'b100};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, words[k], 32'h100 + 32'(4 * k));
      step();
      vectors++;
      if ({in_ready, out_valid, out_imm_sel} !== {1'b1, 1'b1, sels[k]}) begin
        errors++;
        $display("FAIL stream_%0d: got rdy=%b v=%b sel=%b, required 1 1 %b",
                 k, in_ready, out_valid, out_imm_sel, sels[k]);
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_2103, 32'h200);
    step();
    drive(1'b1, 32'h0040_0067, 32'h204);
    step();
    drive(1'b0, 32'h0, 32'h0);
    vectors++;
    if ({in_ready, out_valid, out_instr} !== {1'b0, 1'b1, 32'h0000_2103}) begin
      errors++;
      $display("FAIL bp_full: got rdy=%b v=%b i=%h, required 0 1 00002103",
               in_ready, out_valid, out_instr);
    end
    out_ready = 1'b1;
    step();
    vectors++;
    if ({in_ready, out_valid, out_instr, out_pc} !== {1'b1, 1'b1, 32'h0040_0067, 32'h204}) begin
      errors++;
      $display("FAIL bp_second: got rdy=%b v=%b i=%h pc=%h, required 1 1 00400067 204",
               in_ready, out_valid, out_instr, out_pc);
    end
    step();
    vectors++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got out_valid=%b, required 0", out_valid);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'h0011_2023, 32'h300);
    step();
    drive(1'b1, 32'h0020_8463, 32'h304);
    step();
    flush = 1'b1;
    drive(1'b1, 32'hDEAD_00EF, 32'h308);
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    vectors++;
    if ({out_valid, in_ready, out_instr, out_pc, out_imm_sel} !==
        {1'b0, 1'b1, 32'h13, 32'h0, 3'b001}) begin
      errors++;
      $display("FAIL flush: got v=%b r=%b i=%h pc=%h sel=%b, required 0 1 13 0 001",
               out_valid, in_ready, out_instr, out_pc, out_imm_sel);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (out_valid !== 1'b0 || out_instr === 32'hDEAD_00EF) begin
        errors++;
        $display("FAIL flush_dropped: got v=%b i=%h, required 0 and no dropped word",
                 out_valid, out_instr);
      end
    end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_007F, 32'h400);
    step();
    drive(1'b0, 32'h0, 32'h0);
    vectors++;
`ifdef IF_ID_ILLEGAL_CHECK_EN
    if ({out_illegal, out_imm_sel} !== {1'b1, 3'b001}) begin
      errors++;
      $display("FAIL illegal: got ill=%b sel=%b, required 1 001", out_illegal, out_imm_sel);
    end
`else
    if ({out_illegal, out_imm_sel} !== {1'b0, 3'b001}) begin
      errors++;
      $display("FAIL illegal: got ill=%b sel=%b, required 0 001", out_illegal, out_imm_sel);
    end
`endif
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 32'h0010_0093, 32'h500);
    step();
    drive(1'b1, 32'h0020_0113, 32'h504);
    step();
    rst_n = 1'b0;
    flush = 1'b1;
    step();
    drive(1'b0, 32'h0, 32'h0);
    rst_n = 1'b1;
    flush = 1'b0;
    vectors++;
    if ({out_valid, in_ready, out_pc, out_instr} !== {1'b0, 1'b1, 32'h0, 32'h13}) begin
      errors++;
      $display("FAIL reset_mid: got v=%b r=%b pc=%h i=%h, required 0 1 0 13",
               out_valid, in_ready, out_pc, out_instr);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pool [8];
    logic [31:0] pc;
    int          budget;
    pool = '{32'h0050_0093, 32'h0011_2023, 32'h0020_8463, 32'h0080_00EF,
             32'h1234_52B7, 32'h0000_1517, 32'h0000_2103, 32'h0000_0073};
    pc = 32'h1000;
    for (int k = 0; k < 300; k++) begin
      if (!in_valid || in_ready) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = pool[$urandom_range(0, 7)];
        in_pc    = pc;
        pc       = pc + 4;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    budget    = 10;
    while (sb.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    vectors++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: got %0d pending, v=%b, required 0 pending, v=0",
               sb.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
